// File: rtl/weight_buf_pkg.sv
// weight_buf_pkg: constants, loader states and address type shared by the weight buffer path
package weight_buf_pkg;
    localparam int X_PE         = 16;
    localparam int X_MESH       = 16;
    localparam int ADDR_LEN     = 16;
    localparam int DATA_LEN     = 64;
    localparam int DDR_DATA_LEN = 256;
    localparam int LEN_W        = 20;
    localparam int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN;
    localparam int GROUP_W      = DDR_DATA_LEN / DATA_LEN;
    localparam int GROUP_NUM    = BUFFER_NUM / GROUP_W;
    localparam int GROUP_IW     = $clog2(GROUP_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} load_state_t;
    typedef logic [ADDR_LEN-1:0] addr_t;
endpackage

// File: rtl/wbuf_group_decode.sv
// wbuf_group_decode: bank group index to per-bank write-enable mask, gated by valid
module wbuf_group_decode
    import weight_buf_pkg::*;
(
    input  logic [GROUP_IW-1:0]   group,
    input  logic                  valid,
    output logic [BUFFER_NUM-1:0] mask
);
    assign mask = valid ? {{(BUFFER_NUM-GROUP_W){1'b0}}, {GROUP_W{1'b1}}} << (GROUP_W * group) : '0;
endmodule

// File: rtl/weight_ddr_loader.sv
// weight_ddr_loader: scatters DDR beats across weight buffer banks, one bank group per beat
module weight_ddr_loader
    import weight_buf_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_LEN-1:0]     cmd_base_addr,
    input  logic [LEN_W-1:0]        cmd_beats,
    input  logic [DDR_DATA_LEN-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DDR_DATA_LEN-1:0] data_wr,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [BUFFER_NUM-1:0]   wr_en,
    output logic                    busy,
    output logic                    done
);
    load_state_t           state;
    addr_t                 addr;
    logic [LEN_W-1:0]      remaining;
    logic [GROUP_IW-1:0]   group;
    logic [BUFFER_NUM-1:0] mask;
    logic                  beat;

    assign cmd_ready = state == ST_IDLE;
    assign s_ready   = state == ST_LOAD;
    assign busy      = state != ST_IDLE;
    assign beat      = s_valid && s_ready;

    wbuf_group_decode u_decode (
        .group (group),
        .valid (beat),
        .mask  (mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            group     <= '0;
            data_wr   <= '0;
            wr_addr   <= '0;
            wr_en     <= '0;
            done      <= 1'b0;
        end else begin
            wr_en <= mask;
            done  <= 1'b0;
            // The row address advances only after the last group of a row is written
            if (beat) begin
                data_wr   <= s_data;
                wr_addr   <= addr;
                remaining <= remaining - 1'b1;
                group     <= (group == GROUP_IW'(GROUP_NUM - 1)) ? '0 : group + 1'b1;
                if (group == GROUP_IW'(GROUP_NUM - 1))
                    addr <= addr + 1'b1;
            end
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr      <= cmd_base_addr;
                    remaining <= cmd_beats;
                    group     <= '0;
                    state     <= (cmd_beats == '0) ? ST_DONE : ST_LOAD;
                    done      <= cmd_beats == '0;
                end
                ST_LOAD: if (beat && remaining == LEN_W'(1)) state <= ST_FLUSH;
                ST_FLUSH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_ddr_loader.sv
// tb_weight_ddr_loader: directed and randomized loads checked against a row/group model
module tb_weight_ddr_loader;
    import weight_buf_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [ADDR_LEN-1:0]     cmd_base_addr = '0;
    logic [LEN_W-1:0]        cmd_beats = '0;
    logic [DDR_DATA_LEN-1:0] s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [DDR_DATA_LEN-1:0] data_wr;
    logic [ADDR_LEN-1:0]     wr_addr;
    logic [BUFFER_NUM-1:0]   wr_en;
    logic                    busy;
    logic                    done;

    int checks = 0;
    int failures = 0;
    logic [255:0] exp_data = '0;
    logic [15:0]  exp_addr = '0;

    always #5 clk = ~clk;

    weight_ddr_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_beats     (cmd_beats),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .data_wr       (data_wr),
        .wr_addr       (wr_addr),
        .wr_en         (wr_en),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: s_valid held high, 1: valid every third cycle, 2: random valid
    task automatic run_load(input logic [15:0] base, input int beats, input int mode, input int abort);
        int k;
        int cyc;
        logic v;
        logic [255:0] d;
        cmd_valid = 1'b1;
        cmd_base_addr = base;
        cmd_beats = LEN_W'(beats);
        chk("cmd_ready_idle", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        cmd_base_addr = 16'h1234;
        cmd_beats = 20'd5;
        if (beats == 0) begin
            chk("zero_done", 256'(done), 256'(1));
            chk("zero_busy", 256'(busy), 256'(1));
            chk("zero_wr_en", 256'(wr_en), 256'(0));
        end else begin
            k = 0;
            cyc = 0;
            while (k < beats && cyc < 2000) begin
                if (abort != 0 && k == abort) break;
                chk("s_ready_load", 256'(s_ready), 256'(1));
                chk("cmd_ready_busy", 256'(cmd_ready), 256'(0));
                v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
                for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
                s_valid = v;
                s_data = d;
                @(negedge clk);
                cyc++;
                if (v) begin
                    exp_data = d;
                    exp_addr = 16'(int'(base) + k / GROUP_NUM);
                    chk("wr_en_beat", 256'(wr_en), 256'(32'hF << (4 * (k % GROUP_NUM))));
                    k++;
                end else
                    chk("wr_en_idle", 256'(wr_en), 256'(0));
                chk("data_wr", data_wr, exp_data);
                chk("wr_addr", 256'(wr_addr), 256'(exp_addr));
                chk("done_load", 256'(done), 256'(0));
            end
            s_valid = 1'b0;
            if (abort != 0 && k == abort) begin
                rst_n = 1'b0;
                cmd_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                exp_data = '0;
                exp_addr = '0;
                chk("rst_wr_en", 256'(wr_en), 256'(0));
                chk("rst_done", 256'(done), 256'(0));
                chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
                chk("rst_busy", 256'(busy), 256'(0));
                chk("rst_data_wr", data_wr, 256'(0));
                return;
            end
            chk("beats_in_budget", 256'(k), 256'(beats));
            chk("flush_s_ready", 256'(s_ready), 256'(0));
            chk("flush_done", 256'(done), 256'(0));
            chk("flush_busy", 256'(busy), 256'(1));
            @(negedge clk);
            chk("done_pulse", 256'(done), 256'(1));
            chk("done_wr_en", 256'(wr_en), 256'(0));
            chk("done_busy", 256'(busy), 256'(1));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("after_done", 256'(done), 256'(0));
        chk("after_busy", 256'(busy), 256'(0));
        chk("after_cmd_ready", 256'(cmd_ready), 256'(1));
        chk("after_wr_en", 256'(wr_en), 256'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", 256'(cmd_ready), 256'(1));
        chk("reset_s_ready", 256'(s_ready), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_done", 256'(done), 256'(0));
        chk("reset_wr_en", 256'(wr_en), 256'(0));
        chk("reset_wr_addr", 256'(wr_addr), 256'(0));
        chk("reset_data_wr", data_wr, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        run_load(16'h0010, 8, 0, 0);
        run_load(16'h0010, 10, 0, 0);
        run_load(16'h0000, 0, 0, 0);
        run_load(16'h0020, 8, 1, 0);
        run_load(16'hFFFF, 16, 0, 0);
        run_load(16'h0040, 8, 0, 3);
        run_load(16'h0040, 8, 0, 0);
        for (int t = 0; t < 6; t++)
            run_load(16'($urandom), int'($urandom_range(0, 20)), 2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
